// File: rtl/spi_slave_obi_plug_if.sv
// Signal bundle between the SPI slave controller, the bus sequencer and the OBI fabric.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface spi_slave_obi_plug_if;
   logic [31:0] rx_addr_i;
   logic        rx_rd_wr_i;
   logic        rx_addr_valid_i;
   logic        rx_addr_ready_o;
   logic [31:0] rx_data_i;
   logic        rx_data_valid_i;
   logic        rx_data_ready_o;
   logic [31:0] tx_data_o;
   logic        tx_data_valid_o;
   logic        tx_data_ready_i;
   logic        cs_end_i;
   logic [15:0] wrap_length_i;
   logic        obi_req_o;
   logic        obi_gnt_i;
   logic [31:0] obi_addr_o;
   logic        obi_we_o;
   logic [3:0]  obi_be_o;
   logic [31:0] obi_wdata_o;
   logic        obi_rvalid_i;
   logic [31:0] obi_rdata_i;
   logic        busy_o;

   modport master (
      input  rx_addr_i, rx_rd_wr_i, rx_addr_valid_i, rx_data_i, rx_data_valid_i,
      input  tx_data_ready_i, cs_end_i, wrap_length_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i,
      output rx_addr_ready_o, rx_data_ready_o, tx_data_o, tx_data_valid_o,
      output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, busy_o
   );

   modport slave (
      output rx_addr_i, rx_rd_wr_i, rx_addr_valid_i, rx_data_i, rx_data_valid_i,
      output tx_data_ready_i, cs_end_i, wrap_length_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i,
      input  rx_addr_ready_o, rx_data_ready_o, tx_data_o, tx_data_valid_o,
      input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, busy_o
   );
endinterface

// File: rtl/spi_slave_obi_plug.sv
// SPI slave bus sequencer: turns SPI address/data words into single-word OBI accesses.
// Optional address wrap-around is enabled by defining SPI_OBI_WRAP_EN.
module spi_slave_obi_plug (
   input logic                  clk_i,
   input logic                  rst_ni,
   spi_slave_obi_plug_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, WR_WAIT, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RD_PUSH
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q, next_addr;
   logic        end_q;
   logic        addr_hs, wdata_ld, rdata_ld, advance, end_set;
   logic        req, we, data_rdy, tx_vld;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^bus.rx_addr_i[1:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      addr_hs  = 1'b0;
      wdata_ld = 1'b0;
      rdata_ld = 1'b0;
      advance  = 1'b0;
      end_set  = 1'b0;
      req      = 1'b0;
      we       = 1'b0;
      data_rdy = 1'b0;
      tx_vld   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.rx_addr_valid_i) begin
               addr_hs = 1'b1;
               state_d = bus.rx_rd_wr_i ? RD_REQ : WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (bus.cs_end_i) begin
               state_d = IDLE;
            end else if (bus.rx_data_valid_i) begin
               wdata_ld = 1'b1;
               state_d  = WR_REQ;
            end
         end
         WR_REQ: begin
            req     = 1'b1;
            we      = 1'b1;
            end_set = bus.cs_end_i;
            if (bus.obi_gnt_i) begin
               data_rdy = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            end_set = bus.cs_end_i;
            if (bus.obi_rvalid_i) begin
               advance = 1'b1;
               state_d = (end_q || bus.cs_end_i) ? IDLE : WR_WAIT;
            end
         end
         RD_REQ: begin
            req = 1'b1;
            // A grant in the same cycle as CS end still commits the access.
            if (bus.obi_gnt_i) begin
               end_set = bus.cs_end_i;
               state_d = RD_RESP;
            end else if (bus.cs_end_i) begin
               state_d = IDLE;
            end
         end
         RD_RESP: begin
            end_set = bus.cs_end_i;
            if (bus.obi_rvalid_i) begin
               if (end_q || bus.cs_end_i) begin
                  state_d = IDLE;
               end else begin
                  rdata_ld = 1'b1;
                  state_d  = RD_PUSH;
               end
            end
         end
         RD_PUSH: begin
            tx_vld = 1'b1;
            if (bus.cs_end_i) begin
               state_d = IDLE;
            end else if (bus.tx_data_ready_i) begin
               advance = 1'b1;
               state_d = RD_REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SPI_OBI_WRAP_EN
   logic [31:0] base_q;
   logic [15:0] wrap_q, word_cnt_q;
   logic        wrap_hit;

   assign wrap_hit  = (wrap_q != 16'd0) && ((word_cnt_q + 16'd1) == wrap_q);
   assign next_addr = wrap_hit ? base_q : addr_q + 32'd4;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q     <= '0;
         wrap_q     <= '0;
         word_cnt_q <= '0;
      end else if (addr_hs) begin
         base_q     <= {bus.rx_addr_i[31:2], 2'b00};
         wrap_q     <= bus.wrap_length_i;
         word_cnt_q <= '0;
      end else if (advance) begin
         word_cnt_q <= wrap_hit ? 16'd0 : word_cnt_q + 16'd1;
      end
   end
`else
   logic unused_wrap;

   assign unused_wrap = ^bus.wrap_length_i;
   assign next_addr   = addr_q + 32'd4;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         end_q   <= 1'b0;
      end else begin
         if (addr_hs)       addr_q <= {bus.rx_addr_i[31:2], 2'b00};
         else if (advance)  addr_q <= next_addr;
         if (wdata_ld)      wdata_q <= bus.rx_data_i;
         if (rdata_ld)      rdata_q <= bus.obi_rdata_i;
         if (addr_hs)       end_q <= 1'b0;
         else if (end_set)  end_q <= 1'b1;
      end
   end

   assign bus.rx_addr_ready_o = (state_q == IDLE);
   assign bus.rx_data_ready_o = data_rdy;
   assign bus.tx_data_o       = rdata_q;
   assign bus.tx_data_valid_o = tx_vld;
   assign bus.obi_req_o       = req;
   assign bus.obi_we_o        = we;
   assign bus.obi_addr_o      = addr_q;
   assign bus.obi_wdata_o     = wdata_q;
   assign bus.obi_be_o        = 4'hF;
   assign bus.busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_obi_plug.sv
// Directed bench for spi_slave_obi_plug with an OBI memory responder and
// scoreboards for expected bus accesses and SPI TX words.
module tb_spi_slave_obi_plug;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   spi_slave_obi_plug_if bus();

   spi_slave_obi_plug dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [31:0] tx_q[$];
   bus_exp_t    mon_e;
   logic [31:0] mon_t;

   int n_assert = 0;
   int n_fail = 0;
   int rdy_pulses = 0;
   int tx_seen = 0;
   int tx_vld_cycles = 0;

   logic        gnt_allow;
   int          rsp_delay;
   logic        pend;
   int          wcnt;
   logic [31:0] paddr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a >= 32'h2000 && a <= 32'h2008) return 32'h11 * ((a - 32'h2000) / 4 + 1);
      return a ^ 32'hA5A5_0000;
   endfunction

   // OBI memory responder: combinational grant, rvalid rsp_delay cycles after the
   // cycle following the grant.
   assign bus.obi_gnt_i = bus.obi_req_o & gnt_allow;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.obi_rvalid_i <= 1'b0;
         bus.obi_rdata_i  <= '0;
         pend             <= 1'b0;
         wcnt             <= 0;
         paddr            <= '0;
      end else begin
         bus.obi_rvalid_i <= 1'b0;
         if (pend) begin
            if (wcnt <= 1) begin
               bus.obi_rvalid_i <= 1'b1;
               bus.obi_rdata_i  <= mem_rd(paddr);
               pend             <= 1'b0;
            end else begin
               wcnt <= wcnt - 1;
            end
         end else if (bus.obi_req_o && bus.obi_gnt_i) begin
            if (rsp_delay == 0) begin
               bus.obi_rvalid_i <= 1'b1;
               bus.obi_rdata_i  <= mem_rd(bus.obi_addr_o);
            end else begin
               pend  <= 1'b1;
               wcnt  <= rsp_delay;
               paddr <= bus.obi_addr_o;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.obi_req_o && bus.obi_gnt_i) begin
            if (bus_q.size() == 0) begin
               chk("bus_unexpected_access", bus.obi_addr_o, 32'hFFFF_FFFF);
            end else begin
               mon_e = bus_q.pop_front();
               chk("bus_addr", bus.obi_addr_o, mon_e.addr);
               chk("bus_we", 32'(bus.obi_we_o), 32'(mon_e.we));
               chk("bus_be", 32'(bus.obi_be_o), 32'hF);
               if (mon_e.we) chk("bus_wdata", bus.obi_wdata_o, mon_e.wdata);
            end
         end
         if (bus.rx_data_ready_o) rdy_pulses++;
         if (bus.tx_data_valid_o) begin
            tx_vld_cycles++;
            if (bus.tx_data_ready_i) begin
               tx_seen++;
               if (tx_q.size() == 0) begin
                  chk("tx_unexpected_word", bus.tx_data_o, 32'hFFFF_FFFF);
               end else begin
                  mon_t = tx_q.pop_front();
                  chk("tx_data", bus.tx_data_o, mon_t);
               end
            end
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_req"},        32'(bus.obi_req_o), 32'd0);
      chk({tag, "_we"},         32'(bus.obi_we_o), 32'd0);
      chk({tag, "_rx_rdy"},     32'(bus.rx_data_ready_o), 32'd0);
      chk({tag, "_tx_vld"},     32'(bus.tx_data_valid_o), 32'd0);
      chk({tag, "_busy"},       32'(bus.busy_o), 32'd0);
      chk({tag, "_addr"},       bus.obi_addr_o, 32'd0);
      chk({tag, "_wdata"},      bus.obi_wdata_o, 32'd0);
      chk({tag, "_tx_data"},    bus.tx_data_o, 32'd0);
      chk({tag, "_be"},         32'(bus.obi_be_o), 32'hF);
      chk({tag, "_addr_ready"}, 32'(bus.rx_addr_ready_o), 32'd1);
   endtask

   task automatic send_addr(input logic [31:0] a, input logic rd, input string tag);
      logic ok;
      ok = 1'b0;
      bus.rx_addr_i       = a;
      bus.rx_rd_wr_i      = rd;
      bus.rx_addr_valid_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rx_addr_ready_o) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.rx_addr_valid_i = 1'b0;
      chk({tag, "_addr_accept"}, 32'(ok), 32'd1);
   endtask

   task automatic send_word(input logic [31:0] d, input string tag);
      logic ok;
      ok = 1'b0;
      bus.rx_data_i       = d;
      bus.rx_data_valid_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.rx_data_ready_o) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.rx_data_valid_i = 1'b0;
      chk({tag, "_word_taken"}, 32'(ok), 32'd1);
   endtask

   task automatic cs_pulse();
      bus.cs_end_i = 1'b1;
      @(posedge clk); #1;
      bus.cs_end_i = 1'b0;
   endtask

   // Read burst: expectations already queued; n words are drained then CS ends
   // while the next speculative word waits in the TX stage.
   task automatic do_read(input logic [31:0] a, input int n, input string tag);
      int   lat;
      int   seen0;
      logic ok;
      seen0 = tx_seen;
      bus.tx_data_ready_i = 1'b1;
      send_addr(a, 1'b1, tag);
      lat = 1;
      ok  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.tx_data_valid_o) begin
            ok = 1'b1;
            break;
         end
         lat++;
         @(posedge clk); #1;
      end
      chk({tag, "_first_tx_seen"}, 32'(ok), 32'd1);
      chk({tag, "_first_tx_latency"}, 32'(lat), 32'd3);
      @(posedge clk); #1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (tx_seen - seen0 == n) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      bus.tx_data_ready_i = 1'b0;
      chk({tag, "_tx_count"}, 32'(ok), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.tx_data_valid_o) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk({tag, "_spec_word_pending"}, 32'(ok), 32'd1);
      @(posedge clk); #1;
      cs_pulse();
      @(negedge clk);
      chk({tag, "_tx_vld_after_cs"}, 32'(bus.tx_data_valid_o), 32'd0);
      chk({tag, "_busy_after_cs"}, 32'(bus.busy_o), 32'd0);
      chk({tag, "_bus_q_empty"}, 32'(bus_q.size()), 32'd0);
      chk({tag, "_tx_q_empty"}, 32'(tx_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int          p0;
      int          tvc0;
      logic        ok;
      logic [31:0] a;

      bus.rx_addr_i       = '0;
      bus.rx_rd_wr_i      = 1'b0;
      bus.rx_addr_valid_i = 1'b0;
      bus.rx_data_i       = '0;
      bus.rx_data_valid_i = 1'b0;
      bus.tx_data_ready_i = 1'b0;
      bus.cs_end_i        = 1'b0;
      bus.wrap_length_i   = '0;
      gnt_allow           = 1'b1;
      rsp_delay           = 0;

      #1 rst_n = 1'b0;
      #10;
      chk_reset("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_addr_ready", 32'(bus.rx_addr_ready_o), 32'd1);
      chk("post_rst_busy", 32'(bus.busy_o), 32'd0);
      @(posedge clk); #1;

      // Two-word write burst on a zero-wait bus
      bus_q.push_back('{32'h1000, 1'b1, 32'hAAAA_0001});
      bus_q.push_back('{32'h1004, 1'b1, 32'hAAAA_0002});
      p0 = rdy_pulses;
      send_addr(32'h1000, 1'b0, "wr");
      send_word(32'hAAAA_0001, "wr0");
      send_word(32'hAAAA_0002, "wr1");
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("wr_busy_before_cs", 32'(bus.busy_o), 32'd1);
      chk("wr_ready_pulses", 32'(rdy_pulses - p0), 32'd2);
      chk("wr_bus_q_empty", 32'(bus_q.size()), 32'd0);
      @(posedge clk); #1;
      cs_pulse();
      @(negedge clk);
      chk("wr_busy_after_cs", 32'(bus.busy_o), 32'd0);
      @(posedge clk); #1;

      // Read burst from the small memory table
      for (int k = 0; k < 4; k++) bus_q.push_back('{32'h2000 + 32'(4 * k), 1'b0, 32'h0});
      for (int k = 0; k < 3; k++) tx_q.push_back(mem_rd(32'h2000 + 32'(4 * k)));
      do_read(32'h2000, 3, "rd");

      // Wrap length 2 from 0x3008 (linear when wrapping is compiled out)
      bus.wrap_length_i = 16'd2;
      for (int k = 0; k < 5; k++) begin
`ifdef SPI_OBI_WRAP_EN
         a = 32'h3008 + 32'(4 * (k % 2));
`else
         a = 32'h3008 + 32'(4 * k);
`endif
         bus_q.push_back('{a, 1'b0, 32'h0});
         if (k < 4) tx_q.push_back(mem_rd(a));
      end
      do_read(32'h300B, 4, "wrap");
      bus.wrap_length_i = 16'd0;

      // Write with the grant withheld for five cycles
      gnt_allow = 1'b0;
      bus_q.push_back('{32'h1100, 1'b1, 32'h5555_AAAA});
      send_addr(32'h1100, 1'b0, "stall");
      bus.rx_data_i       = 32'h5555_AAAA;
      bus.rx_data_valid_i = 1'b1;
      @(posedge clk); #1;
      p0 = rdy_pulses;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_req", 32'(bus.obi_req_o), 32'd1);
         chk("stall_we", 32'(bus.obi_we_o), 32'd1);
         chk("stall_addr", bus.obi_addr_o, 32'h1100);
         chk("stall_wdata", bus.obi_wdata_o, 32'h5555_AAAA);
         chk("stall_no_ready", 32'(bus.rx_data_ready_o), 32'd0);
         @(posedge clk); #1;
      end
      gnt_allow = 1'b1;
      @(negedge clk);
      chk("stall_ready_on_grant", 32'(bus.rx_data_ready_o), 32'd1);
      @(posedge clk); #1;
      bus.rx_data_valid_i = 1'b0;
      @(negedge clk);
      chk("stall_ready_dropped", 32'(bus.rx_data_ready_o), 32'd0);
      chk("stall_single_pulse", 32'(rdy_pulses - p0), 32'd1);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
      cs_pulse();
      @(negedge clk);
      chk("stall_busy_after_cs", 32'(bus.busy_o), 32'd0);
      @(posedge clk); #1;

      // CS end while the read response is outstanding
      rsp_delay = 3;
      tvc0 = tx_vld_cycles;
      bus_q.push_back('{32'h4000, 1'b0, 32'h0});
      send_addr(32'h4000, 1'b1, "csrd");
      @(posedge clk); #1;
      cs_pulse();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.obi_rvalid_i) begin
            ok = 1'b1;
            break;
         end
         chk("csrd_busy_while_pending", 32'(bus.busy_o), 32'd1);
         @(posedge clk); #1;
      end
      chk("csrd_rvalid_seen", 32'(ok), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("csrd_idle", 32'(bus.busy_o), 32'd0);
      chk("csrd_no_tx_valid", 32'(tx_vld_cycles - tvc0), 32'd0);
      chk("csrd_bus_q_empty", 32'(bus_q.size()), 32'd0);
      @(posedge clk); #1;
      rsp_delay = 0;
      bus_q.push_back('{32'h5000, 1'b1, 32'h1234_5678});
      send_addr(32'h5002, 1'b0, "after_cs");
      send_word(32'h1234_5678, "after_cs");
      repeat (2) @(posedge clk);
      #1;
      cs_pulse();
      @(negedge clk);
      chk("after_cs_bus_q_empty", 32'(bus_q.size()), 32'd0);
      @(posedge clk); #1;

      // Reset asserted while a write request waits for its grant
      gnt_allow = 1'b0;
      send_addr(32'h6000, 1'b0, "rstwr");
      bus.rx_data_i       = 32'h0BAD_0BAD;
      bus.rx_data_valid_i = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstwr_req_before", 32'(bus.obi_req_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset("rstwr");
      bus.rx_data_valid_i = 1'b0;
      gnt_allow = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rstwr_still_idle", 32'(bus.busy_o), 32'd0);
      chk("rstwr_bus_q_empty", 32'(bus_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_obi_plug.md
# spi_slave_obi_plug

System-clock-side bus sequencer for the SPI slave. Takes the already-synchronised address/command and write-data words produced by the SPI slave controller, runs the matching single-word transactions on an OBI master port with address auto-increment, and returns read words towards the SPI TX path. It is the only OBI master owned by the SPI slave and serialises all of its memory accesses.

## Interface
- No parameters; all widths fixed (32-bit address/data, 16-bit wrap length).
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- rx_addr_i  in  32  start byte address of a burst
- rx_rd_wr_i  in  1  1 = read burst, 0 = write burst; sampled with rx_addr_i
- rx_addr_valid_i / rx_addr_ready_o  in/out  1  address handshake
- rx_data_i  in  32  write data word
- rx_data_valid_i / rx_data_ready_o  in/out  1  write-data handshake
- tx_data_o  out  32  read data word to SPI TX FIFO
- tx_data_valid_o / tx_data_ready_i  out/in  1  read-data handshake
- cs_end_i  in  1  synchronised SPI CS-deassert pulse, one cycle
- wrap_length_i  in  16  burst wrap length in words, 0 = no wrap
- obi_req_o, obi_gnt_i  out/in  1  OBI request/grant
- obi_addr_o  out  32  word-aligned byte address
- obi_we_o  out  1  write enable
- obi_be_o  out  4  byte enables, always 4'hF
- obi_wdata_o  out  32  write data
- obi_rvalid_i  in  1  response valid
- obi_rdata_i  in  32  read response data
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, WR_WAIT, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RD_PUSH.
- IDLE: rx_addr_ready_o=1. On handshake latch addr_q = {rx_addr_i[31:2],2'b00}, base_q = same, dir from rx_rd_wr_i, word_cnt=0; go WR_WAIT or RD_REQ.
- WR_WAIT: on rx_data_valid_i latch obi_wdata_o (no ready yet) → WR_REQ.
- WR_REQ: obi_req_o=1, obi_we_o=1; hold until obi_gnt_i; on grant pulse rx_data_ready_o for that cycle (word consumed) → WR_RESP.
- WR_RESP: wait obi_rvalid_i; then advance address → WR_WAIT.
- RD_REQ: obi_req_o=1, obi_we_o=0; on grant → RD_RESP.
- RD_RESP: on obi_rvalid_i register obi_rdata_i into tx_data_o → RD_PUSH.
- RD_PUSH: tx_data_valid_o=1 until tx_data_ready_i; then advance address → RD_REQ (continuous speculative read).
- Address advance: addr_q += 4 modulo 2^32; word_cnt += 1 (16-bit, wraps 0xFFFF→0).
- cs_end_i: in WR_WAIT, RD_REQ (pre-grant; request dropped same cycle as legal only because req not yet granted is withdrawn next cycle) or RD_PUSH → IDLE next cycle, pending tx word discarded, tx_data_valid_o drops. In WR_REQ/WR_RESP/RD_RESP: latch end flag, finish the bus transaction (never abandon a granted access), then IDLE; read data then discarded.
- New address while busy: not accepted (rx_addr_ready_o=0).
- rx_data_valid_i outside WR_WAIT/WR_REQ ignored.

## Timing
- Reset values: state IDLE; obi_req_o, obi_we_o, rx_data_ready_o, tx_data_valid_o, busy_o = 0; obi_addr_o, obi_wdata_o, tx_data_o = 0; obi_be_o = 4'hF; rx_addr_ready_o = 1 after reset.
- obi_req_o, obi_we_o, obi_addr_o, obi_wdata_o are stable while req high and not granted.
- Read latency, zero-wait bus (gnt same cycle, rvalid next): addr handshake cycle 0, req cycle 1, rvalid cycle 2, tx_data_valid_o cycle 3.
- Write: data accepted in WR_WAIT cycle n, req cycle n+1, rx_data_ready_o pulse on grant cycle.
- One outstanding OBI transaction maximum.
- Reset mid-burst: immediate return to reset values, no bus completion.

## Configuration
- SPI_OBI_WRAP_EN defined: when wrap_length_i ≠ 0 and word_cnt+1 == wrap_length_i at advance, addr_q ← base_q and word_cnt ← 0; wrap_length_i sampled at address handshake.
- Undefined: linear increment only, wrap_length_i ignored, no base_q register.

## Test plan
- Write 0x1000, words 0xAAAA0001, 0xAAAA0002, zero-wait bus -> two OBI writes to 0x1000, 0x1004 with matching wdata, two rx_data_ready_o pulses, busy_o until cs_end_i.
- Read 0x2000, memory 0x11,0x22,0x33, tx_data_ready_i always 1 -> tx words 0x11,0x22,0x33, first tx_data_valid_o 3 cycles after addr handshake.
- Write with obi_gnt_i held low 5 cycles -> req/addr/wdata stable all 5 cycles, single ready pulse on grant.
- SPI_OBI_WRAP_EN, read 0x3008, wrap_length_i=2 -> addresses 0x3008, 0x300C, 0x3008, 0x300C.
- cs_end_i during RD_RESP -> transaction completes on rvalid, no tx_data_valid_o, IDLE next cycle; next address accepted.
- rst_ni low in WR_REQ -> req_o 0 immediately, all outputs at reset values.
